// File: rtl/corelet_ctrl.sv
// Weight-stationary tile sequencer: emits the packed corelet/xmem/pmem instruction word
// for one tile per start pulse (weight load, settle gap, activation stream, OFIFO drain).
module corelet_ctrl #(
  parameter int COL = 8,
  parameter int AW  = 11,
  parameter int GAP = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] x_base,
  input  logic [AW-1:0] p_base,
  input  logic [AW-1:0] len,
  input  logic          acc_mode,
  input  logic          ofifo_valid,
  output logic [33:0]   inst,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_L0   = 3'd1,
    W_LOAD = 3'd2,
    W_GAP  = 3'd3,
    X_L0   = 3'd4,
    X_EXEC = 3'd5,
    DRAIN  = 3'd6,
    DONE   = 3'd7
  } state_t;

  localparam logic [AW:0] COL_C  = (AW+1)'(COL);
  localparam logic [AW:0] GAP_C  = (AW+1)'(GAP);
  localparam logic [AW:0] ONE_C  = (AW+1)'(1);
  localparam logic [AW:0] ZERO_C = (AW+1)'(0);

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   r_q, r_d;
  logic [AW:0]   w_q, w_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] wb_q, wb_d, xb_q, xb_d, pb_q, pb_d, len_q, len_d;
  logic          acc_q, acc_d;
  logic [33:0]   inst_q, inst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [AW:0]   len_ext_s;
  logic          pcen_n_s, pwen_n_s, xcen_n_s;
  logic [AW-1:0] paddr_s, xaddr_s;
  logic          ofrd_s, l0wr_s, l0rd_s, exe_s, kl_s;

  assign len_ext_s = {1'b0, len_q};

  // Next-state, counter and instruction-field decode for the current state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    w_d      = w_q;
    pend_d   = 1'b0;
    wb_d     = wb_q;
    xb_d     = xb_q;
    pb_d     = pb_q;
    len_d    = len_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    pcen_n_s = 1'b1;
    pwen_n_s = 1'b1;
    paddr_s  = '0;
    xcen_n_s = 1'b1;
    xaddr_s  = '0;
    ofrd_s   = 1'b0;
    l0wr_s   = 1'b0;
    l0rd_s   = 1'b0;
    exe_s    = 1'b0;
    kl_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          wb_d    = w_base;
          xb_d    = x_base;
          pb_d    = p_base;
          len_d   = len;
          acc_d   = acc_mode;
          cnt_d   = ZERO_C;
          r_d     = ZERO_C;
          w_d     = ZERO_C;
          state_d = (len == '0) ? DONE : W_L0;
        end else begin
          state_d = IDLE;
        end
      end
      W_L0: begin
        // The L0 write trails the SRAM read by one cycle, hence col+1 cycles.
        if (cnt_q < COL_C) begin
          xcen_n_s = 1'b0;
          xaddr_s  = wb_q + cnt_q[AW-1:0];
        end else begin
          xcen_n_s = 1'b1;
        end
        l0wr_s = (cnt_q != ZERO_C);
        if (cnt_q == COL_C) begin
          state_d = W_LOAD;
          cnt_d   = ZERO_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      W_LOAD: begin
        l0rd_s = 1'b1;
        kl_s   = 1'b1;
        if (cnt_q == COL_C - ONE_C) begin
          state_d = W_GAP;
          cnt_d   = ZERO_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      W_GAP: begin
        if (cnt_q == GAP_C - ONE_C) begin
          state_d = X_L0;
          cnt_d   = ZERO_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      X_L0: begin
        if (cnt_q < len_ext_s) begin
          xcen_n_s = 1'b0;
          xaddr_s  = xb_q + cnt_q[AW-1:0];
        end else begin
          xcen_n_s = 1'b1;
        end
        l0wr_s = (cnt_q != ZERO_C);
        if (cnt_q == len_ext_s) begin
          state_d = X_EXEC;
          cnt_d   = ZERO_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      X_EXEC: begin
        l0rd_s = 1'b1;
        exe_s  = 1'b1;
        if (cnt_q == len_ext_s - ONE_C) begin
          state_d = DRAIN;
          cnt_d   = ZERO_C;
          r_d     = ZERO_C;
          w_d     = ZERO_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      DRAIN: begin
        // pend_q marks a read issued last cycle whose row is written to pmem now.
        ofrd_s = ofifo_valid && (r_q < len_ext_s);
        r_d    = r_q + {{AW{1'b0}}, ofrd_s};
        pend_d = ofrd_s;
        if (pend_q) begin
          pcen_n_s = 1'b0;
          pwen_n_s = 1'b0;
          paddr_s  = pb_q + w_q[AW-1:0];
          w_d      = w_q + ONE_C;
          if (w_q == len_ext_s - ONE_C) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          w_d = w_q;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_q != IDLE);
    inst_d = {acc_q, pcen_n_s, pwen_n_s, paddr_s, xcen_n_s, 1'b1, xaddr_s,
              ofrd_s, l0wr_s, l0rd_s, 2'b00, exe_s, kl_s};
  end

  // State, counters, latched operands and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      w_q     <= '0;
      pend_q  <= 1'b0;
      wb_q    <= '0;
      xb_q    <= '0;
      pb_q    <= '0;
      len_q   <= '0;
      acc_q   <= 1'b0;
      inst_q  <= 34'h1_800C_0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      w_q     <= w_d;
      pend_q  <= pend_d;
      wb_q    <= wb_d;
      xb_q    <= xb_d;
      pb_q    <= pb_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Scoreboard bench for corelet_ctrl: stimulus queues expected addresses, phase patterns and
// per-run totals; a negedge monitor pops and compares as the DUT presents them.
module tb_corelet_ctrl;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
  localparam logic [33:0] ACC_B  = 34'h2_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] w_base, x_base, p_base, len;
  logic        acc_mode;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;

  corelet_ctrl #(.COL(8), .AW(11), .GAP(4)) dut (
    .clk(clk), .reset(reset), .start(start), .w_base(w_base), .x_base(x_base),
    .p_base(p_base), .len(len), .acc_mode(acc_mode), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   busy_at;
    int   done_rel;
    int   n_x, n_l0wr, n_l0rd, n_kl, n_ex, n_rd, n_pw;
    logic acc;
  } run_t;

  run_t run_q[$];
  int   xa_q[$];
  int   pa_q[$];
  int   lo_cyc_q[$];
  int   lo_val_q[$];

  int checks   = 0;
  int failures = 0;
  int gcyc     = 0;
  int stall_mode = 0;
  int ph = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, gcyc);
    end
  endtask

  always @(posedge clk) gcyc <= gcyc + 1;

  // OFIFO valid source: tied high, or the 1,0,0 repeating stall pattern.
  always @(posedge clk) begin
    #1;
    if (stall_mode != 0) begin
      ofifo_valid = (ph % 3 == 0);
      ph++;
    end else begin
      ofifo_valid = 1'b1;
    end
  end

  // Monitor: tracks each run from busy rise to done and checks against the queues.
  int   cyc, n_x, n_l0wr, n_l0rd, n_kl, n_ex, n_rd, n_pw, last_pw, bad_acc, bad_wen;
  logic in_run = 1'b0;
  logic prev_valid = 1'b0;
  run_t cur;
  always @(negedge clk) begin
    if (reset) begin
      in_run = 1'b0;
    end else begin
      if (busy && !in_run) begin
        in_run = 1'b1;
        cyc = 0; n_x = 0; n_l0wr = 0; n_l0rd = 0; n_kl = 0; n_ex = 0; n_rd = 0;
        n_pw = 0; last_pw = -1; bad_acc = 0; bad_wen = 0;
        if (run_q.size() == 0) chk("unexpected_run", 1, 0);
        else chk("busy_latency", gcyc, run_q[0].busy_at);
      end
      if (in_run) begin
        if (inst[18] !== 1'b1) bad_wen++;
        if (run_q.size() != 0 && inst[33] !== run_q[0].acc) bad_acc++;
        if (inst[19] == 1'b0) begin
          n_x++;
          if (xa_q.size() == 0) chk("xmem_extra_read", 1, 0);
          else chk("xmem_addr", inst[17:7], xa_q.pop_front());
        end
        if (inst[32] == 1'b0) begin
          n_pw++;
          last_pw = cyc;
          chk("pmem_wen_n", inst[31], 0);
          if (pa_q.size() == 0) chk("pmem_extra_write", 1, 0);
          else chk("pmem_addr", inst[30:20], pa_q.pop_front());
        end
        if (inst[6]) begin
          n_rd++;
          chk("ofifo_rd_when_valid", prev_valid, 1);
        end
        if (inst[5]) n_l0wr++;
        if (inst[4]) n_l0rd++;
        if (inst[1]) n_ex++;
        if (inst[0]) n_kl++;
        if (lo_cyc_q.size() != 0 && lo_cyc_q[0] == cyc) begin
          void'(lo_cyc_q.pop_front());
          chk("phase_bits", inst[6:0], lo_val_q.pop_front());
        end
        if (done) begin
          if (run_q.size() == 0) begin
            chk("done_without_run", 1, 0);
          end else begin
            cur = run_q.pop_front();
            if (cur.done_rel >= 0) chk("done_cycle", cyc, cur.done_rel);
            if (cur.n_pw > 0) chk("done_after_last_write", cyc, last_pw + 1);
            chk("busy_at_done", busy, 1);
            chk("n_xmem_reads", n_x, cur.n_x);
            chk("n_l0_wr", n_l0wr, cur.n_l0wr);
            chk("n_l0_rd", n_l0rd, cur.n_l0rd);
            chk("n_kernel_load", n_kl, cur.n_kl);
            chk("n_execute", n_ex, cur.n_ex);
            chk("n_ofifo_rd", n_rd, cur.n_rd);
            chk("n_pmem_writes", n_pw, cur.n_pw);
            chk("acc_held", bad_acc, 0);
            chk("xmem_wen_high", bad_wen, 0);
            chk("xmem_queue_empty", xa_q.size(), 0);
            chk("pmem_queue_empty", pa_q.size(), 0);
          end
          in_run = 1'b0;
        end
        cyc++;
      end
    end
    prev_valid = ofifo_valid;
  end

  // Drives one start pulse and queues everything the run must produce.
  task automatic start_run(input int wb, input int xb, input int pb, input int l,
                           input logic acc, input int done_rel);
    run_t r;
    w_base = 11'(wb); x_base = 11'(xb); p_base = 11'(pb); len = 11'(l); acc_mode = acc;
    r.busy_at = gcyc + 2;
    r.done_rel = done_rel;
    r.acc = acc;
    if (l == 0) begin
      r.n_x = 0; r.n_l0wr = 0; r.n_l0rd = 0; r.n_kl = 0;
    end else begin
      r.n_x = 8 + l; r.n_l0wr = 8 + l; r.n_l0rd = 8 + l; r.n_kl = 8;
      for (int i = 0; i < 8; i++) xa_q.push_back((wb + i) & 32'h7FF);
      for (int i = 0; i < l; i++) xa_q.push_back((xb + i) & 32'h7FF);
      for (int i = 0; i < l; i++) pa_q.push_back((pb + i) & 32'h7FF);
      for (int i = 0; i <= 21; i++) begin
        lo_cyc_q.push_back(i);
        if (i >= 1 && i <= 8) lo_val_q.push_back(32'h20);
        else if (i >= 9 && i <= 16) lo_val_q.push_back(32'h11);
        else lo_val_q.push_back(0);
      end
    end
    r.n_ex = l; r.n_rd = l; r.n_pw = l;
    run_q.push_back(r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w_base = 11'h5A5; x_base = 11'h3C3; p_base = 11'h111; len = 11'd7; acc_mode = ~acc;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (done) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("done_timeout", 0, 1);
    run_q.delete(); xa_q.delete(); pa_q.delete(); lo_cyc_q.delete(); lo_val_q.delete();
  endtask

  int ba;
  initial begin
    reset = 1'b1; start = 1'b0; acc_mode = 1'b0; ofifo_valid = 1'b1;
    w_base = '0; x_base = '0; p_base = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_inst", inst, IDLE_W);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Abort in W_L0: reset mid-run must return the idle word in the same cycle.
    start_run(11'h010, 11'h100, 11'h200, 16, 1'b0, 71);
    ba = run_q[0].busy_at;
    while (gcyc < ba + 3) begin @(posedge clk); #1; end
    run_q.delete(); xa_q.delete(); pa_q.delete(); lo_cyc_q.delete(); lo_val_q.delete();
    reset = 1'b1;
    #1;
    chk("abort_inst", inst, IDLE_W);
    chk("abort_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Full tile with a stray start pulse during X_EXEC.
    start_run(11'h010, 11'h100, 11'h200, 16, 1'b0, 71);
    ba = run_q[0].busy_at;
    while (gcyc < ba + 45) begin @(posedge clk); #1; end
    len = 11'd3; w_base = 11'h222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);

    // Drain stall with acc_mode=1 held through and after done.
    stall_mode = 1;
    start_run(11'h020, 11'h300, 11'h040, 16, 1'b1, -1);
    wait_done(400);
    chk("acc_after_done", inst, IDLE_W | ACC_B);
    stall_mode = 0;
    @(posedge clk); #1;

    // len=0: done two cycles after start, no SRAM traffic.
    start_run(11'h000, 11'h000, 11'h000, 0, 1'b0, 0);
    wait_done(20);
    chk("idle_after_len0", inst, IDLE_W);

    // Address wrap on both SRAMs.
    start_run(11'h7FC, 11'h7FE, 11'h7FE, 4, 1'b0, 35);
    wait_done(100);
    chk("idle_final", inst, IDLE_W);
    chk("run_queue_drained", run_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
